ql_fcb_clkgate_ctl: RTL



---
 rtl/ql_fcb_clkgate_ctl.sv | 113 +++++++++++
 1 files changed

// File: rtl/ql_fcb_clkgate_ctl.sv
// Gate-enable controller for ql_clkgate_x4. It adds a wake delay before ack and an idle hold after
// the request drops. gate_en is retimed on the falling edge so the gate cell never passes a runt pulse.
module ql_fcb_clkgate_ctl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CNT_W  = 8,
  parameter int WCNT_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  force_on,
  input  logic [IDLE_CNT_W-1:0] idle_limit,
  output logic                  gate_en,
  output logic                  ack,
  output logic [1:0]            state_o,
  output logic [WCNT_W-1:0]     wake_count
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [3:0]            WAKE_LOAD = 4'(WAKE_CYCLES - 1);
  localparam logic [IDLE_CNT_W-1:0] HCNT_ONE  = IDLE_CNT_W'(1);
  localparam logic [WCNT_W-1:0]     WCNT_ONE  = WCNT_W'(1);

  logic                  want;
  logic [1:0]            state_reg, state_next;
  logic [3:0]            wcnt_reg, wcnt_next;
  logic [IDLE_CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [WCNT_W-1:0]     wake_count_reg, wake_count_next;
  logic                  en_reg;
  logic                  ack_reg;
  logic                  gate_en_reg;

  assign want = req | force_on;

  always_comb begin
    state_next      = state_reg;
    wcnt_next       = wcnt_reg;
    hcnt_next       = hcnt_reg;
    wake_count_next = wake_count_reg;
    case (state_reg)
      ST_OFF: begin
        if (want) begin
          state_next = ST_WAKE;
          wcnt_next  = WAKE_LOAD;
          if (wake_count_reg != '1)
            wake_count_next = wake_count_reg + WCNT_ONE;
        end
      end
      ST_WAKE: begin
        // Wake always completes; a dropped request is handled once in ON.
        if (wcnt_reg == 4'd0)
          state_next = ST_ON;
        else
          wcnt_next = wcnt_reg - 4'd1;
      end
      ST_ON: begin
        if (!want) begin
          if (idle_limit == '0) begin
            state_next = ST_OFF;
          end else begin
            state_next = ST_HOLD;
            hcnt_next  = idle_limit - HCNT_ONE;
          end
        end
      end
      default: begin
        // A returning request beats hold expiry on the same edge.
        if (want)
          state_next = ST_ON;
        else if (hcnt_reg == '0)
          state_next = ST_OFF;
        else
          hcnt_next = hcnt_reg - HCNT_ONE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg      <= ST_OFF;
      wcnt_reg       <= 4'd0;
      hcnt_reg       <= '0;
      wake_count_reg <= '0;
      en_reg         <= 1'b0;
      ack_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wcnt_reg       <= wcnt_next;
      hcnt_reg       <= hcnt_next;
      wake_count_reg <= wake_count_next;
      en_reg         <= (state_next != ST_OFF);
      ack_reg        <= (state_next == ST_ON) || (state_next == ST_HOLD);
    end
  end

  // Changes only while clk_in is low, so the downstream AND-style gate sees a stable enable.
  always_ff @(negedge clk_in) begin
    if (rst)
      gate_en_reg <= 1'b0;
    else
      gate_en_reg <= en_reg;
  end

  assign gate_en    = gate_en_reg;
  assign ack        = ack_reg;
  assign state_o    = state_reg;
  assign wake_count = wake_count_reg;

endmodule
